// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between the UART datapath and baud_tick_gen.
// The master drives the divisor and phase controls; the slave returns the ticks.
interface baud_tick_gen_if #(
    parameter int CNT_W  = 16,
    parameter int FRAC_W = 4,
    parameter int PH_W   = 4
);
    logic              enable;
    logic              load;
    logic [CNT_W-1:0]  divisor_int;
    logic [FRAC_W-1:0] divisor_frac;
    logic              resync;
    logic              os_tick;
    logic              mid_tick;
    logic              bit_tick;
    logic [PH_W-1:0]   os_phase;

    modport master (
        output enable, load, divisor_int, divisor_frac, resync,
        input  os_tick, mid_tick, bit_tick, os_phase
    );

    modport slave (
        input  enable, load, divisor_int, divisor_frac, resync,
        output os_tick, mid_tick, bit_tick, os_phase
    );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud/oversample tick generator with bit and mid-bit ticks.
// Phase can be restarted by a divisor load or by an RX start-bit resync.
module baud_tick_gen #(
    parameter int CNT_W      = 16,
    parameter int FRAC_W     = 4,
    parameter int OVERSAMPLE = 16,
    parameter int DEF_INT    = 434,
    parameter int DEF_FRAC   = 0
) (
    input logic            clock,
    input logic            reset,
    baud_tick_gen_if.slave bus
);
    localparam int PH_W = $clog2(OVERSAMPLE);
    localparam logic [PH_W-1:0] HALF = PH_W'(OVERSAMPLE / 2);
    localparam logic [CNT_W-1:0] DEF_I =
        (DEF_INT < 2) ? CNT_W'(2) : CNT_W'(DEF_INT);
    localparam logic [FRAC_W-1:0] DEF_F = FRAC_W'(DEF_FRAC);

    logic [CNT_W-1:0]  div_i;
    logic [CNT_W-1:0]  cnt;
    logic [FRAC_W-1:0] div_f;
    logic [FRAC_W-1:0] acc;
    logic [FRAC_W:0]   acc_sum;
    logic              carry;
    logic              term;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_nxt;
    logic              os_q;
    logic              mid_q;
    logic              bit_q;

    // A period shorter than two clocks would make ticks back-to-back.
    function automatic logic [CNT_W-1:0] clamp_div(
        input logic [CNT_W-1:0] v
    );
        return (v < CNT_W'(2)) ? CNT_W'(2) : v;
    endfunction

    always_comb begin
        acc_sum   = {1'b0, acc} + {1'b0, div_f};
        carry     = acc_sum[FRAC_W];
        term      = carry ? (cnt == div_i)
                          : (cnt == div_i - CNT_W'(1));
        phase_nxt = phase + PH_W'(1);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            div_i <= DEF_I;
            div_f <= DEF_F;
            cnt   <= '0;
            acc   <= '0;
            phase <= '0;
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
        end else if (bus.load) begin
            div_i <= clamp_div(bus.divisor_int);
            div_f <= bus.divisor_frac;
            cnt   <= '0;
            acc   <= '0;
            phase <= '0;
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
        end else if (bus.resync) begin
            cnt   <= '0;
            phase <= '0;
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
        end else if (bus.enable) begin
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
            if (term) begin
                cnt   <= '0;
                acc   <= acc_sum[FRAC_W-1:0];
                phase <= phase_nxt;
                os_q  <= 1'b1;
                mid_q <= (phase_nxt == HALF);
                bit_q <= (phase_nxt == '0);
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end else begin
            os_q  <= 1'b0;
            mid_q <= 1'b0;
            bit_q <= 1'b0;
        end
    end

    assign bus.os_tick  = os_q;
    assign bus.mid_tick = mid_q;
    assign bus.bit_tick = bit_q;
    assign bus.os_phase = phase;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Bench for baud_tick_gen: period-level reference model plus directed
// scenarios with hand-computed tick timings.
module tb_baud_tick_gen;
    logic clock = 1'b0;
    logic reset = 1'b0;

    always #5 clock = ~clock;

    baud_tick_gen_if #(.CNT_W(16), .FRAC_W(4), .PH_W(4)) bus ();

    baud_tick_gen #(
        .CNT_W(16), .FRAC_W(4), .OVERSAMPLE(16),
        .DEF_INT(434), .DEF_FRAC(0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                         nm, act, exp, cyc);
        end
    endtask

    // Reference model: whole periods, tick count modulo 16.
    int m_di, m_df, m_acc, m_left, m_n;
    bit e_os, e_mid, e_bit;

    function automatic int per();
        return m_di + (((m_acc + m_df) >= 16) ? 1 : 0);
    endfunction

    always @(posedge clock) begin
        cyc++;
        e_os = 0; e_mid = 0; e_bit = 0;
        if (!reset) begin
            m_di = 434; m_df = 0; m_acc = 0; m_n = 0;
            m_left = per();
        end else if (bus.load) begin
            m_di = (bus.divisor_int < 2) ? 2 : int'(bus.divisor_int);
            m_df = int'(bus.divisor_frac);
            m_acc = 0; m_n = 0;
            m_left = per();
        end else if (bus.resync) begin
            m_n = 0;
            m_left = per();
        end else if (bus.enable) begin
            m_left--;
            if (m_left == 0) begin
                e_os  = 1;
                m_n   = (m_n + 1) % 16;
                e_mid = (m_n == 8);
                e_bit = (m_n == 0);
                m_acc = (m_acc + m_df) % 16;
                m_left = per();
            end
        end
    end

    // Observations of the DUT, cleared by the stimulus between scenarios.
    int n_os, mid_n, bit_n, bit_t, ph_first, consec;
    int ttime [0:127];
    bit prev_os = 0;
    bit checking = 0;

    always @(posedge clock) begin
        #1;
        if (checking) begin
            check("outputs",
                  int'({bus.os_tick, bus.mid_tick, bus.bit_tick,
                        bus.os_phase}),
                  int'({e_os, e_mid, e_bit, 4'(m_n)}));
            if (bus.os_tick && prev_os) consec++;
            if (bus.os_tick) begin
                if (n_os < 128) ttime[n_os] = cyc;
                if (n_os == 0) ph_first = int'(bus.os_phase);
                n_os++;
                if (bus.mid_tick && mid_n == 0) mid_n = n_os;
                if (bus.bit_tick && bit_n == 0) begin
                    bit_n = n_os;
                    bit_t = cyc;
                end
            end
        end
        prev_os = bus.os_tick;
    end

    task automatic clear_obs();
        n_os = 0; mid_n = 0; bit_n = 0; bit_t = 0;
        ph_first = -1; consec = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic wait_ticks(input int target, input int budget,
                              input string nm);
        int b = 0;
        while (n_os < target && b < budget) begin
            @(negedge clock);
            b++;
        end
        check({nm, "_timeout"}, n_os >= target, 1);
    endtask

    task automatic do_load(input int di, input int df, input bit rs);
        bus.load = 1'b1;
        bus.resync = rs;
        bus.divisor_int = 16'(di);
        bus.divisor_frac = 4'(df);
        step(1);
        bus.load = 1'b0;
        bus.resync = 1'b0;
    endtask

    int rel, t0;

    initial begin
        bus.enable = 1'b1;
        bus.load = 1'b0;
        bus.resync = 1'b0;
        bus.divisor_int = 16'd7;
        bus.divisor_frac = 4'd3;
        clear_obs();
        step(1);
        checking = 1;
        step(2);
        check("reset_outputs",
              int'({bus.os_tick, bus.mid_tick, bus.bit_tick,
                    bus.os_phase}), 0);

        // Default divisor after reset release.
        reset = 1'b1;
        rel = cyc;
        clear_obs();
        wait_ticks(16, 8000, "def");
        check("def_first_tick", ttime[0] - rel, 434);
        check("def_gap", ttime[1] - ttime[0], 434);
        check("def_mid_index", mid_n, 8);
        check("def_bit_index", bit_n, 16);
        check("def_bit_time", bit_t - rel, 6944);

        // 115200 baud: 54 + 4/16.
        do_load(54, 4, 0);
        rel = cyc;
        clear_obs();
        wait_ticks(64, 4000, "frac");
        check("frac_first", ttime[0] - rel, 54);
        check("frac_gap1", ttime[1] - ttime[0], 54);
        check("frac_gap2", ttime[2] - ttime[1], 54);
        check("frac_gap3", ttime[3] - ttime[2], 55);
        check("frac_span64", ttime[63] - rel, 3472);
        wait_ticks(65, 200, "frac65");

        // Resync with acc=4 must keep the accumulator: 54,54,55.
        bus.resync = 1'b1;
        step(1);
        bus.resync = 1'b0;
        rel = cyc;
        clear_obs();
        wait_ticks(3, 400, "rs_acc");
        check("rs_acc_third", ttime[2] - rel, 163);
        check("rs_acc_phase", ph_first, 1);

        // Resync at cnt=200 of a 434 period.
        do_load(434, 0, 0);
        step(200);
        bus.resync = 1'b1;
        step(1);
        bus.resync = 1'b0;
        rel = cyc;
        clear_obs();
        wait_ticks(1, 600, "rs");
        check("rs_first", ttime[0] - rel, 434);
        check("rs_phase", ph_first, 1);

        // Enable low for 100 clocks mid-period.
        t0 = ttime[0];
        step(100);
        bus.enable = 1'b0;
        clear_obs();
        step(100);
        check("en_low_ticks", n_os, 0);
        bus.enable = 1'b1;
        wait_ticks(1, 600, "en");
        check("en_delay", ttime[0] - t0, 534);
        check("en_phase", ph_first, 2);

        // div_i=1 clamps to 2; load beats a simultaneous resync.
        do_load(1, 0, 1);
        rel = cyc;
        clear_obs();
        wait_ticks(20, 100, "min");
        check("min_first", ttime[0] - rel, 2);
        check("min_span20", ttime[19] - rel, 40);
        check("min_consec", consec, 0);

        // One-cycle reset mid-bit restores the default divisor.
        bus.divisor_int = 16'd999;
        step(5);
        reset = 1'b0;
        step(1);
        check("rst_outputs",
              int'({bus.os_tick, bus.mid_tick, bus.bit_tick,
                    bus.os_phase}), 0);
        reset = 1'b1;
        rel = cyc;
        clear_obs();
        wait_ticks(1, 600, "rst");
        check("rst_first", ttime[0] - rel, 434);
        check("rst_phase", ph_first, 1);

        step(2);
        checking = 0;
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
